// File: rtl/zero_padding_stream_pkg.sv
// Shared definitions for the streaming zero-padder: FSM states, default
// element width and elaboration-time helpers for the padded geometry.
package zero_padding_stream_pkg;

    // Default element width of the feature-map stream.
    localparam int DATA_LEN_DEFAULT = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // Bits needed to hold 0..n-1, never fewer than one.
    function automatic int clog2_min1(input int n);
        int bits;
        bits = 1;
        while ((1 << bits) < n) bits++;
        return bits;
    endfunction

    // One padded dimension: n plus a border of width pad on each side.
    function automatic int pad_dim(input int n, input int pad);
        return n + 2 * pad;
    endfunction

    // Output beats in one padded frame.
    function automatic int pad_total(input int ch, input int h, input int w, input int pad);
        return ch * pad_dim(h, pad) * pad_dim(w, pad);
    endfunction

endpackage

// File: rtl/pad_index_counter.sv
// Three-level (channel, row, column) position counter over the output map.
// Row/column limits follow the latched mode, so the same counter walks the
// padded map or the bare map. Reports whether the current position is an
// interior (input-backed) element and whether it is the final one.
module pad_index_counter
    import zero_padding_stream_pkg::*;
#(
    parameter int CH  = 32,
    parameter int H   = 3,
    parameter int W   = 4,
    parameter int PAD = 1,
    localparam int C_W = clog2_min1(CH),
    localparam int R_W = clog2_min1(pad_dim(H, PAD)),
    localparam int X_W = clog2_min1(pad_dim(W, PAD))
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clear,
    input  logic i_adv,
    input  logic i_pad_mode,
    output logic o_interior,
    output logic o_last
);

    logic [C_W-1:0] r_c;
    logic [R_W-1:0] r_r;
    logic [X_W-1:0] r_x;

    logic [R_W-1:0] w_r_lo, w_r_hi, w_r_max;
    logic [X_W-1:0] w_x_lo, w_x_hi, w_x_max;
    logic           w_c_wrap, w_r_wrap, w_x_wrap;

    // Runtime bounds: interior window and wrap points for the latched mode.
    always_comb begin
        // NOTE: every signal gets a value on every path through a combinational
        // block; a path that leaves one unassigned infers a latch.
        w_r_lo  = '0;
        w_x_lo  = '0;
        w_r_hi  = R_W'(H - 1);
        w_x_hi  = X_W'(W - 1);
        w_r_max = R_W'(H - 1);
        w_x_max = X_W'(W - 1);
        if (i_pad_mode) begin
            w_r_lo  = R_W'(PAD);
            w_x_lo  = X_W'(PAD);
            w_r_hi  = R_W'(PAD + H - 1);
            w_x_hi  = X_W'(PAD + W - 1);
            w_r_max = R_W'(pad_dim(H, PAD) - 1);
            w_x_max = X_W'(pad_dim(W, PAD) - 1);
        end
    end

    assign w_x_wrap   = (r_x == w_x_max);
    assign w_r_wrap   = (r_r == w_r_max);
    assign w_c_wrap   = (r_c == C_W'(CH - 1));
    assign o_last     = w_c_wrap && w_r_wrap && w_x_wrap;
    assign o_interior = (r_r >= w_r_lo) && (r_r <= w_r_hi) &&
                        (r_x >= w_x_lo) && (r_x <= w_x_hi);

    // Column fastest, then row, then channel; cleared at frame start.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples the pre-edge values regardless of statement order.
        if (!rst_n) begin
            r_c <= '0;
            r_r <= '0;
            r_x <= '0;
        end else if (i_clear) begin
            r_c <= '0;
            r_r <= '0;
            r_x <= '0;
        end else if (i_adv) begin
            if (w_x_wrap) begin
                r_x <= '0;
                if (w_r_wrap) begin
                    r_r <= '0;
                    r_c <= w_c_wrap ? '0 : r_c + 1'b1;
                end else begin
                    r_r <= r_r + 1'b1;
                end
            end else begin
                r_x <= r_x + 1'b1;
            end
        end
    end

endmodule

// File: rtl/zero_padding_stream.sv
// Streaming zero-padder: consumes a CH x H x W map one element per beat and
// emits the CH x (H+2*PAD) x (W+2*PAD) map, generating border zeros itself.
// pad_en=0 at start turns the block into a plain pass-through for one frame.
module zero_padding_stream
    import zero_padding_stream_pkg::*;
#(
    parameter int DATA_LEN = DATA_LEN_DEFAULT,
    parameter int CH       = 32,
    parameter int H        = 3,
    parameter int W        = 4,
    parameter int PAD      = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic                pad_en,
    input  logic                s_valid,
    output logic                s_ready,
    input  logic [DATA_LEN-1:0] s_data,
    output logic                m_valid,
    input  logic                m_ready,
    output logic [DATA_LEN-1:0] m_data,
    output logic                m_last,
    output logic                busy,
    output logic                done
);

    state_t              r_state, w_next_state;
    logic                r_mode;
    logic                r_m_valid;
    logic [DATA_LEN-1:0] r_m_data;
    logic                r_m_last;
    logic                r_done;

    logic w_out_free, w_adv, w_out_hs, w_start_frame;
    logic w_interior, w_last_pos, w_s_ready;

    pad_index_counter #(
        .CH  (CH),
        .H   (H),
        .W   (W),
        .PAD (PAD)
    ) u_index (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_clear    (w_start_frame),
        .i_adv      (w_adv),
        .i_pad_mode (r_mode),
        .o_interior (w_interior),
        .o_last     (w_last_pos)
    );

    assign w_out_free    = !r_m_valid || m_ready;
    assign w_out_hs      = r_m_valid && m_ready;
    assign w_start_frame = (r_state == ST_IDLE) && start;

    // Next state plus the load/accept strobes of the output register.
    always_comb begin
        w_next_state = r_state;
        w_s_ready    = 1'b0;
        w_adv        = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) w_next_state = ST_RUN;
            end
            ST_RUN: begin
                w_s_ready = w_interior && w_out_free;
                w_adv     = w_out_free && (!w_interior || s_valid);
                if (w_adv && w_last_pos) w_next_state = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (w_out_hs) w_next_state = ST_IDLE;
            end
            default: w_next_state = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_next_state;
    end

    // Mode latch: only a start accepted from IDLE may change it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)             r_mode <= 1'b1;
        else if (w_start_frame) r_mode <= pad_en;
    end

    // Single-stage output register: border zeros or the accepted input.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_m_valid <= 1'b0;
            r_m_data  <= '0;
            r_m_last  <= 1'b0;
        end else if (w_adv) begin
            r_m_valid <= 1'b1;
            r_m_data  <= w_interior ? s_data : '0;
            r_m_last  <= w_last_pos;
        end else if (m_ready) begin
            r_m_valid <= 1'b0;
            r_m_last  <= 1'b0;
        end
    end

    // Completion pulse, one cycle after the final element leaves.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_done <= 1'b0;
        else        r_done <= (r_state == ST_DRAIN) && w_out_hs;
    end

    assign s_ready = w_s_ready;
    assign m_valid = r_m_valid;
    assign m_data  = r_m_data;
    assign m_last  = r_m_last;
    assign busy    = (r_state != ST_IDLE);
    assign done    = r_done;

endmodule
